// File: rtl/dff_ring_loader.sv
// Frame controller for a circular DFF ring: round-robin loads DEPTH words from two
// producers, then lets the ring recirculate for a programmed number of full turns.
module dff_ring_loader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ROT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ROT_W-1:0]  rot_count,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              ring_wr,
  output logic [DATA_W-1:0] ring_data,
  output logic              head,
  output logic              busy,
  output logic              done,
  output logic [2:0]        load_cnt
);

  localparam int              PH_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(DEPTH - 1);
  localparam logic [2:0]      CNT_LAST = 3'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CIRC,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_last_b;
  logic [ROT_W-1:0]    r_rot_rem;
  logic [PH_W-1:0]     r_phase;
  logic                r_armed;
  logic                r_ring_wr;
  logic [DATA_W-1:0]   r_ring_data;
  logic                r_head;
  logic                r_busy;
  logic                r_done;
  logic [2:0]          r_load_cnt;

  logic                w_in_load;
  logic                w_gnt_a;
  logic                w_gnt_b;
  logic                w_gnt;
  logic [DATA_W-1:0]   w_gnt_data;
  logic [PH_W-1:0]     w_phase_nxt;

  // NOTE: grants are continuous assigns of registered state and inputs, so
  // they fall the instant reset forces IDLE and no latch can be inferred.
  assign w_in_load   = (r_state == S_LOAD);
  assign w_gnt_a     = w_in_load && req_a && (!req_b || r_last_b);
  assign w_gnt_b     = w_in_load && req_b && (!req_a || !r_last_b);
  assign w_gnt       = w_gnt_a | w_gnt_b;
  assign w_gnt_data  = w_gnt_a ? data_a : data_b;
  assign w_phase_nxt = (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;

  // Phase tracks where word 0 sits in the ring; it starts the cycle word 0 is
  // written and head fires whenever word 0 has come all the way round.
  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_last_b    <= 1'b1;
      r_rot_rem   <= '0;
      r_phase     <= '0;
      r_armed     <= 1'b0;
      r_ring_wr   <= 1'b0;
      r_ring_data <= '0;
      r_head      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_load_cnt  <= '0;
    end else begin
      r_ring_wr <= 1'b0;
      r_done    <= 1'b0;
      if (r_armed) begin
        r_phase <= w_phase_nxt;
        r_head  <= (r_phase == PH_LAST);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_load_cnt <= '0;
            r_rot_rem  <= rot_count;
          end
        end

        S_LOAD: begin
          if (w_gnt) begin
            r_ring_data <= w_gnt_data;
            r_ring_wr   <= 1'b1;
            r_load_cnt  <= r_load_cnt + 3'd1;
            r_last_b    <= w_gnt_b;
            if (!r_armed) begin
              r_armed <= 1'b1;
              r_phase <= '0;
            end
            if (r_load_cnt == CNT_LAST) begin
              if (r_rot_rem != '0) begin
                r_state <= S_CIRC;
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_armed <= 1'b0;
                r_head  <= 1'b0;
              end
            end
          end
        end

        S_CIRC: begin
          if (r_head) begin
            if (r_rot_rem == ROT_W'(1)) begin
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_armed   <= 1'b0;
              r_head    <= 1'b0;
              r_rot_rem <= '0;
            end else begin
              r_rot_rem <= r_rot_rem - ROT_W'(1);
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_a     = w_gnt_a;
  assign gnt_b     = w_gnt_b;
  assign ring_wr   = r_ring_wr;
  assign ring_data = r_ring_data;
  assign head      = r_head;
  assign busy      = r_busy;
  assign done      = r_done;
  assign load_cnt  = r_load_cnt;

endmodule

// File: doc/dff_ring_loader.md
# dff_ring_loader

Controller that shares the 4-stage circular DFF link between two producers: it round-robin arbitrates their word requests, sequences exactly DEPTH writes into the ring, then lets the ring rotate for a programmed number of full turns while flagging when the first loaded word is at the ring output. It sits between the producers and the ring's WR/input_data pins and owns the ring for the whole frame.

## Interface
- DATA_W, 8, word width (matches ring input_data/output_data)
- DEPTH, 4, ring stages; the ring shifts one stage every CLK edge (WR=1 loads input_data, WR=0 recirculates)
- ROT_W, 8, width of rotation count
- CLK  in  1  single clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- start  in  1  frame start pulse, accepted only in IDLE
- rot_count  in  ROT_W  full rotations to run after loading; sampled when start is accepted
- req_a / req_b  in  1  producer request; held with data until granted
- data_a / data_b  in  DATA_W  producer word
- gnt_a / gnt_b  out  1  combinational grant; word is taken in the grant cycle
- ring_wr  out  1  registered, drives ring WR
- ring_data  out  DATA_W  registered, drives ring input_data
- head  out  1  registered; ring output holds word 0 of the frame this cycle
- busy  out  1  high in LOAD and CIRCULATE
- done  out  1  one-cycle pulse in DONE
- load_cnt  out  3  words loaded this frame (0..DEPTH)

## Operation
- States: IDLE, LOAD, CIRCULATE, DONE. Reset → IDLE; all outputs 0, last-grant register = B (so A wins first tie), rotation and phase counters 0.
- IDLE: start=1 → LOAD; load_cnt ← 0; rot_count latched.
- LOAD: at most one grant per cycle. Only one req → grant it. Both → grant the one not granted last. Grant cycle edge: ring_data ← granted data, ring_wr ← 1, load_cnt +1, last-grant updated. Non-grant cycle: ring_wr ← 0 (ring rotates; word order in the circle is preserved). Edge of the DEPTH-th grant → CIRCULATE if latched rot_count ≠ 0, else DONE.
- CIRCULATE: no grants, ring_wr ← 0. Each cycle with head=1 decrements the remaining-rotation counter; the edge ending the cycle of the rot_count-th head → DONE.
- DONE: done=1, busy=0, gnt=0 for one cycle, then IDLE unconditionally; start here is ignored.
- gnt_a/gnt_b are 0 outside LOAD, regardless of req.
- load_cnt holds its final value through IDLE until the next accepted start.

## Timing
- Let t0 = cycle ring_wr first equals 1 in a frame (ring_data = word 0); t0 is one cycle after the first grant.
- Because the ring shifts every edge, word 0 is at ring output in cycles t0+4+4k, k ≥ 0, independent of gaps between grants. head=1 exactly on those cycles while busy; 0 otherwise.
- head cycles falling in LOAD are not counted as rotations.
- Back-to-back grants in cycles g..g+3: ring_wr=1 in g+1..g+4 (first CIRCULATE cycle still shows word 3 being written), CIRCULATE from g+4.
- Rotation counter is ROT_W bits; rot_count = 2^ROT_W−1 runs that many turns, no wrap.
- RST low at any time: immediate return to IDLE with reset values; partial frame discarded, grants drop same cycle.

## Test plan
- Reset, start with rot_count=1, req_a held with 0x11,0x22,0x33,0x44 → gnt_a cycles g..g+3, ring_wr 1 for g+1..g+4, head at g+5, done at g+6, load_cnt=4, ring output 0x11 at g+5.
- Both req held from start (A=0xA0.., B=0xB0..) → grant order A,B,A,B; ring holds A0,B0,A1,B1 in order.
- Gapped requests (grants in cycles 2,5,6,10 after start) → head strictly every 4 cycles from t0+4, ring output at head = first word.
- rot_count=0 → DONE the cycle after the 4th grant, no CIRCULATE, head never counted; rot_count=3 → exactly 3 head pulses then done.
- start pulsed during LOAD/CIRCULATE/DONE → ignored, no restart, load_cnt unaffected.
- RST low mid-CIRCULATE → all outputs 0 asynchronously; after release, new start runs a clean frame with A getting first tie.
